// File: rtl/led7seg_595_scan_ctrl.sv
// Eight-digit 7-segment scanner driving a 74HC595 pair: {seg, sel} words shifted MSB first.
// Define LED7SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module led7seg_595_scan_ctrl #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    output logic       sclk,
    output logic       rclk,
    output logic       dio,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {StIdle, StLoad, StShLo, StShHi, StLtHi, StLtLo} state_e;

    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

    state_e      state;
    logic [2:0]  digit;
    logic [7:0]  div;
    logic [3:0]  bitcnt;
    logic [14:0] shreg;
    logic [4:0]  shadow [8];
    logic [4:0]  active [8];

    logic [4:0]  cur;
    logic [7:0]  seg;
    logic [15:0] word;

    function automatic logic [7:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: hex2seg = 8'hC0;
            4'h1: hex2seg = 8'hF9;
            4'h2: hex2seg = 8'hA4;
            4'h3: hex2seg = 8'hB0;
            4'h4: hex2seg = 8'h99;
            4'h5: hex2seg = 8'h92;
            4'h6: hex2seg = 8'h82;
            4'h7: hex2seg = 8'hF8;
            4'h8: hex2seg = 8'h80;
            4'h9: hex2seg = 8'h90;
            4'hA: hex2seg = 8'h88;
            4'hB: hex2seg = 8'h83;
            4'hC: hex2seg = 8'hC6;
            4'hD: hex2seg = 8'hA1;
            4'hE: hex2seg = 8'h86;
            default: hex2seg = 8'h8E;
        endcase
    endfunction

`ifdef LED7SEG_LEADING_ZERO_BLANK_EN
    logic blank;
    logic lead;

    // A digit is blank while it and every digit above it are plain zero.
    always_comb begin
        lead  = 1'b1;
        blank = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            lead = lead && (active[i] == 5'd0);
            if (digit == 3'(i)) blank = lead;
        end
    end
`endif

    // Digit 0 reads shadow directly since active is being refreshed in that same LOAD cycle.
    always_comb begin
        cur = (digit == 3'd0) ? shadow[0] : active[digit];
        seg = hex2seg(cur[3:0]);
        if (cur[4]) seg[7] = 1'b0;
`ifdef LED7SEG_LEADING_ZERO_BLANK_EN
        if (blank) seg = 8'hFF;
`endif
        word = {seg, 8'd1 << digit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
        end else if (wr_en) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            digit      <= '0;
            div        <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            sclk       <= 1'b0;
            rclk       <= 1'b0;
            dio        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 8; i++) active[i] <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (en) begin
                        state <= StLoad;
                        busy  <= 1'b1;
                    end
                end
                StLoad: begin
                    if (digit == 3'd0) active <= shadow;
                    shreg  <= word[14:0];
                    dio    <= word[15];
                    div    <= '0;
                    bitcnt <= '0;
                    state  <= StShLo;
                end
                StShLo: begin
                    if (div == DivLast) begin
                        div   <= '0;
                        sclk  <= 1'b1;
                        state <= StShHi;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                StShHi: begin
                    if (div == DivLast) begin
                        div  <= '0;
                        sclk <= 1'b0;
                        if (bitcnt == 4'd15) begin
                            dio   <= 1'b0;
                            rclk  <= 1'b1;
                            state <= StLtHi;
                        end else begin
                            bitcnt <= bitcnt + 4'd1;
                            dio    <= shreg[14];
                            shreg  <= {shreg[13:0], 1'b0};
                            state  <= StShLo;
                        end
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                StLtHi: begin
                    if (div == DivLast) begin
                        div   <= '0;
                        rclk  <= 1'b0;
                        state <= StLtLo;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                StLtLo: begin
                    if (div == DivLast) begin
                        div        <= '0;
                        digit      <= digit + 3'd1;
                        frame_done <= (digit == 3'd7);
                        if (en) begin
                            state <= StLoad;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
